// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory block server.
// PREFETCH is only reachable when IMEM_PREFETCH_EN is defined.
package imem_pkg;

   localparam int unsigned BLOCK_BYTES = 16;
   localparam int unsigned BLOCK_W     = 128;
   localparam int unsigned BADDR_W     = 6;
   localparam int unsigned MEM_BYTES   = 1024;
   localparam int unsigned BYTE_ADDR_W = 10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY     = 2'd1,
      DONE     = 2'd2,
      PREFETCH = 2'd3
   } state_t;

endpackage

// File: rtl/imem_byte_array.sv
// 1024x8 instruction storage: byte write port plus combinational 16-byte block read.
// Identical in both IMEM_PREFETCH_EN builds.
module imem_byte_array
   import imem_pkg::*;
(
   input  logic                   clock,
   input  logic                   we,
   input  logic [BYTE_ADDR_W-1:0] waddr,
   input  logic [7:0]             wdata,
   input  logic [BADDR_W-1:0]     raddr,
   output logic [BLOCK_W-1:0]     rdata
);

   logic [7:0] mem [MEM_BYTES];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   // Byte k of the block lands in bits [8k+7:8k].
   always_comb begin
      rdata = '0;
      for (int unsigned k = 0; k < BLOCK_BYTES; k++)
         rdata[8*k +: 8] = mem[{raddr, 4'(k)}];
   end

endmodule

// File: rtl/imem_block_server.sv
// Block-refill server for the instruction cache with busywait handshake.
// Define IMEM_PREFETCH_EN to add next-block prefetch into a one-entry buffer.
module imem_block_server
   import imem_pkg::*;
#(
   parameter int unsigned LATENCY = 4
`ifdef IMEM_PREFETCH_EN
   ,
   parameter int unsigned PF_LATENCY = 4
`endif
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   read,
   input  logic [BADDR_W-1:0]     address,
   output logic [BLOCK_W-1:0]     readdata,
   output logic                   busywait,
   input  logic                   prog_we,
   input  logic [BYTE_ADDR_W-1:0] prog_addr,
   input  logic [7:0]             prog_data
);

   localparam int unsigned CNT_W = 8;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   counter;
   logic [BADDR_W-1:0] addr_latched;
   logic [BADDR_W-1:0] rd_blk;
   logic [BLOCK_W-1:0] blk_data;
   logic               cnt_zero;

   assign cnt_zero = (counter == '0);

`ifdef IMEM_PREFETCH_EN
   logic [BLOCK_W-1:0] pf_buf;
   logic [BADDR_W-1:0] pf_tag;
   logic [CNT_W-1:0]   pf_cnt;
   logic               pf_valid, pf_req;
   logic               pf_match, pf_hit, pf_wr_hit, fill_done;

   assign pf_match  = read && (address == pf_tag);
   assign pf_hit    = pf_valid && pf_match;
   assign pf_wr_hit = prog_we && (prog_addr[BYTE_ADDR_W-1 -: BADDR_W] == pf_tag);
   assign fill_done = (state == PREFETCH) && (pf_cnt == '0);
   assign rd_blk    = (state == PREFETCH) ? pf_tag : addr_latched;
`else
   assign rd_blk = addr_latched;
`endif

   imem_byte_array u_array (
      .clock (clock),
      .we    (prog_we),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (rd_blk),
      .rdata (blk_data)
   );

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
`ifdef IMEM_PREFETCH_EN
            if (read) state_nx = pf_hit ? DONE : BUSY;
`else
            if (read) state_nx = BUSY;
`endif
         end
         BUSY: if (cnt_zero) state_nx = DONE;
`ifdef IMEM_PREFETCH_EN
         DONE: state_nx = PREFETCH;
         PREFETCH: begin
            // A request for the block being filled waits for the fill; any other aborts it.
            if (pf_req || pf_match) begin
               if (fill_done) state_nx = DONE;
            end else if (read) begin
               state_nx = BUSY;
            end else if (fill_done) begin
               state_nx = IDLE;
            end
         end
`else
         DONE: state_nx = IDLE;
`endif
         default: state_nx = IDLE;
      endcase
   end

   // busywait must rise in the same cycle as read, so it is decoded combinationally.
   always_comb begin
      busywait = 1'b0;
      if (reset) begin
         case (state)
            IDLE:     busywait = read;
            BUSY:     busywait = 1'b1;
`ifdef IMEM_PREFETCH_EN
            PREFETCH: busywait = read || pf_req;
`endif
            default:  busywait = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         counter      <= '0;
         addr_latched <= '0;
         readdata     <= '0;
`ifdef IMEM_PREFETCH_EN
         pf_buf   <= '0;
         pf_tag   <= '0;
         pf_cnt   <= '0;
         pf_valid <= 1'b0;
         pf_req   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (read) begin
                  addr_latched <= address;
`ifdef IMEM_PREFETCH_EN
                  if (pf_hit) readdata <= pf_buf;
                  else        counter  <= CNT_W'(LATENCY - 1);
`else
                  counter <= CNT_W'(LATENCY - 1);
`endif
               end
            end
            BUSY: begin
               if (cnt_zero) readdata <= blk_data;
               else          counter  <= counter - CNT_W'(1);
            end
`ifdef IMEM_PREFETCH_EN
            DONE: begin
               pf_tag   <= addr_latched + BADDR_W'(1);
               pf_cnt   <= CNT_W'(PF_LATENCY - 1);
               pf_valid <= 1'b0;
               pf_req   <= 1'b0;
            end
            PREFETCH: begin
               if (pf_req || pf_match) begin
                  if (fill_done) begin
                     readdata     <= blk_data;
                     addr_latched <= pf_tag;
                     pf_buf       <= blk_data;
                     pf_valid     <= 1'b1;
                     pf_req       <= 1'b0;
                  end else begin
                     pf_req <= 1'b1;
                     pf_cnt <= pf_cnt - CNT_W'(1);
                  end
               end else if (read) begin
                  pf_valid     <= 1'b0;
                  addr_latched <= address;
                  counter      <= CNT_W'(LATENCY - 1);
               end else if (fill_done) begin
                  pf_buf   <= blk_data;
                  pf_valid <= 1'b1;
               end else begin
                  pf_cnt <= pf_cnt - CNT_W'(1);
               end
            end
`endif
            default: ;
         endcase
`ifdef IMEM_PREFETCH_EN
         // Any program write into the buffered block makes the buffer stale.
         if (pf_wr_hit) pf_valid <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_imem_block_server.sv
// Directed bench for imem_block_server; extra prefetch steps run when IMEM_PREFETCH_EN is defined.
module tb_imem_block_server;
   import imem_pkg::*;

   logic                   clock = 1'b0;
   logic                   reset;
   logic                   read;
   logic [BADDR_W-1:0]     address;
   logic [BLOCK_W-1:0]     readdata;
   logic                   busywait;
   logic                   prog_we;
   logic [BYTE_ADDR_W-1:0] prog_addr;
   logic [7:0]             prog_data;

   int errors = 0;
   int checks = 0;
   int n;
   logic [BLOCK_W-1:0] exp_blk;

   imem_block_server dut (
      .clock     (clock),
      .reset     (reset),
      .read      (read),
      .address   (address),
      .readdata  (readdata),
      .busywait  (busywait),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [BLOCK_W-1:0] ramp(input logic [7:0] base);
      logic [BLOCK_W-1:0] b;
      b = '0;
      for (int k = 0; k < 16; k++) b[8*k +: 8] = base + 8'(k);
      return b;
   endfunction

   task automatic check(input string tag, input logic [BLOCK_W-1:0] got,
                        input logic [BLOCK_W-1:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load_block(input logic [BADDR_W-1:0] blk, input logic [7:0] base);
      for (int k = 0; k < 16; k++) begin
         prog_we   = 1'b1;
         prog_addr = {blk, 4'(k)};
         prog_data = base + 8'(k);
         tick();
      end
      prog_we = 1'b0;
   endtask

   // Counts consecutive busywait-high cycles, starting with the current one.
   task automatic busy_len(output int cnt);
      cnt = 0;
      #1;
      while (busywait === 1'b1 && cnt < 40) begin
         cnt++;
         @(posedge clock);
         #2;
      end
   endtask

   initial begin
      reset     = 1'b0;
      read      = 1'b1;
      address   = '0;
      prog_we   = 1'b0;
      prog_addr = '0;
      prog_data = '0;

      // Reset held low two cycles with read asserted
      #1 check("rst_busy_pre", 128'(busywait), 128'(0));
      tick(); #1;
      check("rst_busy_c1", 128'(busywait), 128'(0));
      check("rst_data_c1", readdata, '0);
      tick(); #1;
      check("rst_busy_c2", 128'(busywait), 128'(0));
      check("rst_data_c2", readdata, '0);
      reset = 1'b1;
      read  = 1'b0;
      #1 check("idle_busy", 128'(busywait), 128'(0));

      tick();
      load_block(6'd4, 8'h00);
      load_block(6'd5, 8'h50);
      load_block(6'd9, 8'h90);

      // Basic fetch of block 4, read held through completion
      read    = 1'b1;
      address = 6'd4;
      busy_len(n);
      check("lat_blk4", 128'(n), 128'(5));
      check("data_blk4", readdata, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
      check("done_low", 128'(busywait), 128'(0));

      // Back-to-back: block 9 accepted in the cycle after DONE
      address = 6'd9;
      tick();
      busy_len(n);
      check("lat_b2b_blk9", 128'(n), 128'(5));
      check("data_blk9", readdata, ramp(8'h90));
      read = 1'b0;

      // Program write during BUSY, before the completion edge
      tick();
      read    = 1'b1;
      address = 6'd4;
      tick();
      read      = 1'b0;
      prog_we   = 1'b1;
      prog_addr = 10'h045;
      prog_data = 8'hAA;
      tick();
      prog_we = 1'b0;
      busy_len(n);
      check("lat_rest", 128'(n), 128'(3));
      exp_blk = ramp(8'h00);
      exp_blk[8*5 +: 8] = 8'hAA;
      check("data_wr_busy", readdata, exp_blk);

      // Program write landing exactly on the completion edge
      tick();
      read    = 1'b1;
      address = 6'd4;
      tick();
      read = 1'b0;
      tick();
      tick();
      tick();
      prog_we   = 1'b1;
      prog_addr = 10'h045;
      prog_data = 8'hBB;
      tick();
      prog_we = 1'b0;
      #1;
      check("done_low_wr", 128'(busywait), 128'(0));
      check("data_wr_edge_old", readdata, exp_blk);
      tick();
      read    = 1'b1;
      address = 6'd4;
      busy_len(n);
      check("lat_after_wr", 128'(n), 128'(5));
      exp_blk[8*5 +: 8] = 8'hBB;
      check("data_wr_edge_new", readdata, exp_blk);
      read = 1'b0;

      // Reset pulsed in the second BUSY cycle aborts the request
      tick();
      read    = 1'b1;
      address = 6'd4;
      tick();
      read = 1'b0;
      tick();
      reset = 1'b0;
      #1 check("rst_mid_busy", 128'(busywait), 128'(0));
      tick();
      reset = 1'b1;
      #1;
      check("abort_data", readdata, '0);
      check("abort_busy", 128'(busywait), 128'(0));
      for (int i = 0; i < 4; i++) tick();
      check("abort_no_done", readdata, '0);
      read    = 1'b1;
      address = 6'd4;
      busy_len(n);
      check("lat_after_abort", 128'(n), 128'(5));
      check("data_after_abort", readdata, exp_blk);
      read = 1'b0;

`ifdef IMEM_PREFETCH_EN
      // Block 5 prefetched after the block-4 read: served in one busy cycle
      for (int i = 0; i < 6; i++) tick();
      read    = 1'b1;
      address = 6'd5;
      busy_len(n);
      check("pf_hit_lat", 128'(n), 128'(1));
      check("pf_hit_data", readdata, ramp(8'h50));
      read = 1'b0;
      tick();
      // Mismatched request during the block-6 prefetch aborts it
      read    = 1'b1;
      address = 6'd7;
      busy_len(n);
      check("pf_abort_lat", 128'(n), 128'(5));
      read = 1'b0;
`endif

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_block_server.md
Name: imem_block_server

Overview:
- Instruction-memory stage directly downstream of the instruction cache; answers its block-refill requests.
- Holds 1024 bytes as 64 blocks of 16 bytes and returns one 128-bit block per request after a fixed multi-cycle latency, using a busywait handshake.
- A byte-wide program port loads the image before or between fetches.

Parameters:
- LATENCY, 4, number of busy cycles from request acceptance to data return; legal range 1..255.
- PF_LATENCY, 4, prefetch fill time in cycles; used only with IMEM_PREFETCH_EN.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- read  in  1  block read request from the cache.
- address  in  6  block address {tag,index}.
- readdata  out  128  returned block; byte k is at bits [8k+7:8k], k = 0..15.
- busywait  out  1  high while a request is pending.
- prog_we  in  1  byte write strobe for program load.
- prog_addr  in  10  byte address for program load.
- prog_data  in  8  byte to write.

Behaviour:
- Reset (reset = 0 at a clock edge):
  - state goes to IDLE; counter = 0; readdata = 0.
  - busywait is forced to 0 while reset is low.
  - Memory contents are not cleared.
- States: IDLE, BUSY, DONE.
- busywait is combinational: (IDLE and read) or BUSY. It therefore rises in the same cycle read rises, before the cache samples it.
- IDLE:
  - With read = 1 at the edge: latch address, set counter = LATENCY-1, go to BUSY.
- BUSY:
  - Counter decrements each edge.
  - At the edge where counter = 0: assemble the block from mem[{addr_latched,0..15}] into readdata, then go to DONE.
  - Changes on address or read during BUSY are ignored; an accepted request always completes.
- DONE:
  - busywait = 0 for exactly one cycle, then IDLE unconditionally.
- readdata holds its value until the next completion.
- Back-to-back requests: if read is still 1 in the IDLE cycle after DONE, a new request is accepted.
- Minimum request-to-data time is LATENCY+1 edges.
- Program writes:
  - prog_we = 1 at an edge writes mem[prog_addr] = prog_data in every state.
  - A write landing on the completion edge of the same block is not visible in that readdata; it is seen by the next read.
- Mid-operation reset: aborts BUSY; no data is returned.
- address is 6 bits, so no out-of-range case exists.

Optional Feature:
- Macro: IMEM_PREFETCH_EN.
- With it defined:
  - Adds state PREFETCH, plus a 128-bit pf_buf, a 6-bit pf_tag and a pf_valid flag.
  - After DONE, go to PREFETCH targeting (addr_latched+1) mod 64; it fills over PF_LATENCY cycles, then sets pf_valid and returns to IDLE.
  - IDLE request with pf_valid and address == pf_tag: one BUSY cycle, readdata = pf_buf, then DONE.
  - Request arriving during PREFETCH:
    - matching the target: wait for the remaining fill, then serve it.
    - otherwise: abort the prefetch (pf_valid = 0) and start a normal BUSY.
  - prog_we inside block pf_tag clears pf_valid.
  - Reset clears pf_valid.
- Without it: no prefetch logic; timing is exactly as specified in Behaviour.

Decomposition:
- Package imem_pkg holds:
  - BLOCK_BYTES = 16, BLOCK_W = 128, BADDR_W = 6, MEM_BYTES = 1024.
  - The state encoding (IDLE, BUSY, DONE, PREFETCH).
- Sub-module imem_byte_array:
  - 1024x8 storage, with the byte write port.
  - Combinational 16-byte block read port indexed by block address.

Test Plan:
- Reset low for 2 cycles with read = 1 -> busywait = 0, readdata = 0; after release, state is IDLE.
- Load bytes 0x00..0x0F at addresses 0x040..0x04F; read with address = 4 held until busywait falls -> busywait high for exactly 5 cycles (LATENCY = 4); readdata = 0x0F0E..0100 (byte k = k); busywait low for 1 cycle.
- Two requests, address 4 then 9, with read held high -> second accepted in the IDLE cycle after DONE; readdata for 9 returned 5 cycles later.
- prog_we to 0x045 (value 0xAA) during BUSY of block 4, before the completion edge -> readdata byte 5 = 0xAA; the same write on the completion edge is seen only on the next read.
- reset pulsed low in the 2nd BUSY cycle -> no completion; readdata stays 0; next read of block 4 takes full latency.
- IMEM_PREFETCH_EN: read block 4, wait 6 cycles, read block 5 -> busywait high 1 cycle with block 5 data. Then read block 7 during the prefetch of block 6 -> prefetch aborted and full LATENCY applies.
